keypad_scan: RTL and testbench

//  Scanner for a 4x4 matrix keypad. It time-multiplexes the column drives (one column
//  low at a time) and samples the rows, so it is the input-side counterpart of the

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_col_scan.sv | 33 +++
 rtl/keypad_scan.sv | 186 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_t;
  typedef enum logic [1:0] {RES_NONE, RES_ONE, RES_MULTI} kp_result_t;

  // Index of the lowest active-low row bit; only meaningful when some bit is low.
  function automatic logic [1:0] first_low(input logic [3:0] rows);
    if (!rows[0]) begin
      return 2'd0;
    end else if (!rows[1]) begin
      return 2'd1;
    end else if (!rows[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column time-multiplexer: free-running dwell counter, active-low column drive,
// end-of-dwell sample strobe and end-of-sweep strobe.
module keypad_col_scan #(
  parameter int unsigned N = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample,
  output logic       sweep_end
);

  logic [N+1:0] q_q, q_d;

  assign q_d = q_q + (N+2)'(1);

  // col is registered from the next count so it stays aligned with col_idx, glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
      col <= 4'b1110;
    end else begin
      q_q <= q_d;
      col <= ~(4'b0001 << q_d[N+1:N]);
    end
  end

  assign col_idx   = q_q[N+1:N];
  assign sample    = &q_q[N-1:0];
  assign sweep_end = sample && (col_idx == 2'd3);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row synchronizer, per-sweep accumulator, sweep-level debounce FSM
// and a one-entry valid/ack key buffer.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned DB_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_held,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(DB_SCANS + 1);

  logic [1:0] col_idx;
  logic       sample;
  logic       sweep_end;

  keypad_col_scan #(
    .N (N)
  ) u_col_scan (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .col_idx   (col_idx),
    .sample    (sample),
    .sweep_end (sweep_end)
  );

  logic [3:0] row_s1_q, row_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  // Sweep accumulator: saturating press count and first key seen this sweep.
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [KEY_W-1:0] acc_key_q, acc_key_d;
  logic [3:0]       hits;
  logic [2:0]       pop;
  logic [3:0]       sum;
  kp_result_t       res_next;

  assign hits = ~row_s2_q;
  assign pop  = {2'b00, hits[0]} + {2'b00, hits[1]} + {2'b00, hits[2]} + {2'b00, hits[3]};
  assign sum  = {2'b00, acc_cnt_q} + {1'b0, pop};

  always_comb begin
    acc_cnt_d = (sum >= 4'd2) ? 2'd2 : sum[1:0];
    acc_key_d = (acc_cnt_q == 2'd0) ? {first_low(row_s2_q), col_idx} : acc_key_q;
    unique case (acc_cnt_d)
      2'd0:    res_next = RES_NONE;
      2'd1:    res_next = RES_ONE;
      default: res_next = RES_MULTI;
    endcase
  end

  logic             res_valid_q;
  kp_result_t       res_q;
  logic [KEY_W-1:0] res_code_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q   <= '0;
      acc_key_q   <= '0;
      res_valid_q <= 1'b0;
      res_q       <= RES_NONE;
      res_code_q  <= '0;
    end else begin
      res_valid_q <= 1'b0;
      if (sample) begin
        if (sweep_end) begin
          res_valid_q <= 1'b1;
          res_q       <= res_next;
          res_code_q  <= acc_key_d;
          acc_cnt_q   <= '0;
          acc_key_q   <= '0;
        end else begin
          acc_cnt_q <= acc_cnt_d;
          acc_key_q <= acc_key_d;
        end
      end
    end
  end

  // Debounce FSM, stepped once per sweep result.
  kp_state_t        state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             emit;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (res_valid_q) begin
      unique case (state_q)
        IDLE: begin
          if (res_q == RES_ONE) begin
            state_d = DEBOUNCE;
            cand_d  = res_code_q;
            cnt_d   = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (res_q == RES_ONE && res_code_q == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DB_SCANS)) begin
              emit    = 1'b1;
              state_d = PRESSED;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (res_q == RES_NONE) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (res_q == RES_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DB_SCANS)) begin
              state_d = IDLE;
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      key_held <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      key_held <= (state_d == PRESSED) || (state_d == RELEASE);
    end
  end

  // One-entry buffer; an ack in the emit cycle frees the slot for the new key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (emit) begin
      if (!key_valid || key_ack) begin
        key_code  <= cand_q;
        key_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_ack && key_valid) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan with N=2 (16-clk sweep), DB_SCANS=4.
module tb_keypad_scan;

  localparam int unsigned N  = 2;
  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_held;
  logic        overrun;
  logic [15:0] keys = 16'h0000;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  // Keypad model: row r pulled low while a pressed key {r,c} has its column driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if ((keys[r*4 +: 4] & ~col) != 4'h0) row[r] = 1'b0;
    end
  end

  keypad_scan #(
    .N        (N),
    .DB_SCANS (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Returns at the first negedge of the next sweep (col just returned to 1110).
  task automatic wait_sweep();
    int t;
    t = 0;
    while (col == 4'b1110 && t < 40) begin
      @(negedge clk);
      t++;
    end
    while (col != 4'b1110 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_checks++;
      $error("FAIL sweep_timeout: col stuck at %b", col);
    end
  endtask

  task automatic wait_sweeps(input int n);
    repeat (n) wait_sweep();
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  function automatic logic [15:0] key(input int code);
    return 16'(1) << code;
  endfunction

  initial begin
    int t;

    // Reset state and column stepping
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_code", key_code, 4'h0);
    reset = 1'b0;
    check("col0", col, 4'b1110);
    repeat (4) @(negedge clk);
    check("col1", col, 4'b1101);
    repeat (4) @(negedge clk);
    check("col2", col, 4'b1011);
    repeat (4) @(negedge clk);
    check("col3", col, 4'b0111);
    repeat (4) @(negedge clk);
    check("col_wrap", col, 4'b1110);

    // Clean press of key 6, then release
    wait_sweep();
    keys = key(6);
    t = 0;
    while (!key_valid && t < 83) begin
      @(negedge clk);
      t++;
    end
    check("press_valid", key_valid, 1'b1);
    check("press_code", key_code, 4'h6);
    check("press_held", key_held, 1'b1);
    wait_sweeps(4);
    keys = '0;
    wait_sweeps(4);
    check("release_held_pre", key_held, 1'b1);
    @(negedge clk);
    check("release_held", key_held, 1'b0);
    wait_sweeps(4);
    check("no_repeat_valid", key_valid, 1'b1);
    check("no_repeat_overrun", overrun, 1'b0);
    pulse_ack();
    check("ack_clears", key_valid, 1'b0);

    // Bounce: 2 on, 1 off, 2 on
    wait_sweep();
    keys = key(6);
    wait_sweeps(2);
    keys = '0;
    wait_sweeps(1);
    keys = key(6);
    wait_sweeps(2);
    keys = '0;
    wait_sweeps(6);
    check("bounce_valid", key_valid, 1'b0);
    check("bounce_held", key_held, 1'b0);

    // Two keys together, then drop one
    keys = key(0) | key(5);
    wait_sweeps(8);
    check("multi_valid", key_valid, 1'b0);
    check("multi_held", key_held, 1'b0);
    keys = key(0);
    wait_sweeps(4);
    check("single_pre", key_valid, 1'b0);
    @(negedge clk);
    check("single_valid", key_valid, 1'b1);
    check("single_code", key_code, 4'h0);
    keys = '0;
    pulse_ack();
    wait_sweeps(6);

    // Overrun: second key while first unread
    keys = key(6);
    wait_sweeps(5);
    keys = '0;
    wait_sweeps(6);
    keys = key(15);
    wait_sweeps(5);
    check("ovr_code", key_code, 4'h6);
    check("ovr_valid", key_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    pulse_ack();
    check("ovr_ack_valid", key_valid, 1'b0);
    check("ovr_ack_flag", overrun, 1'b0);
    keys = '0;
    wait_sweeps(6);

    // Ack coinciding with an emission
    keys = key(6);
    wait_sweeps(5);
    keys = '0;
    wait_sweeps(6);
    keys = key(5);
    repeat (64) @(negedge clk);
    check("coinc_pre_valid", key_valid, 1'b1);
    check("coinc_pre_code", key_code, 4'h6);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("coinc_code", key_code, 4'h5);
    check("coinc_valid", key_valid, 1'b1);
    check("coinc_overrun", overrun, 1'b0);
    keys = '0;
    pulse_ack();
    wait_sweeps(6);

    // Reset while debouncing (cnt=3), key kept held
    wait_sweep();
    keys = key(6);
    wait_sweeps(3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_col", col, 4'b1110);
    reset = 1'b0;
    repeat (64) @(negedge clk);
    check("post_rst_valid_pre", key_valid, 1'b0);
    check("post_rst_held_pre", key_held, 1'b0);
    @(negedge clk);
    check("post_rst_valid", key_valid, 1'b1);
    check("post_rst_code", key_code, 4'h6);
    check("post_rst_held", key_held, 1'b1);
    keys = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
